// File: rtl/locked_reg_write_arbiter.sv
// Arbitrated write path into a bank of lockable configuration registers.
// Requesters are served round-robin, one transaction per three cycles
// (IDLE capture, EXEC check/write, RESP status pulse). Lock bits are sticky
// until resetn; nothing, including a trusted debug write, can override them.
//
// state | meaning
// IDLE  | arbitrate, pulse req_ready to the winner, capture its request
// EXEC  | check address, lock, debug permission; perform at most one write
// RESP  | pulse rsp_valid to the winner with the stored status
module locked_reg_write_arbiter #(
    parameter int NREQ  = 2,
    parameter int NREGS = 4,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic                  Clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_data,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ-1:0]       req_debug,
    input  logic                  debug_mode,
    input  logic                  trusted,
    input  logic                  lock_all,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [NREGS*DW-1:0]   reg_out,
    output logic [NREGS-1:0]      lock_status
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] RS_OK       = 2'b00;
    localparam logic [1:0] RS_LOCKED   = 2'b01;
    localparam logic [1:0] RS_DENIED   = 2'b10;
    localparam logic [1:0] RS_BAD_ADDR = 2'b11;

    // One extra bit so an out-of-range address is compared, never truncated.
    localparam logic [AW:0] NREGS_EXT = (AW+1)'(NREGS);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          lock_req_q, lock_req_d;
    logic          debug_q, debug_d;
    logic [IW-1:0] winner_q, winner_d;
    logic [1:0]    status_q, status_d;
    logic [DW-1:0] reg_q [NREGS];
    logic [DW-1:0] reg_d [NREGS];
    logic [NREGS-1:0] lock_q, lock_d;

    logic          grant_found;
    logic [IW-1:0] grant_id;
    logic [IW:0]   arb_idx;
    logic          sel_locked;
    logic          addr_bad;

    // Round-robin search: first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        arb_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (arb_idx >= (IW+1)'(NREQ)) begin
                arb_idx = arb_idx - (IW+1)'(NREQ);
            end
            if (!grant_found && req_valid[arb_idx[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = arb_idx[IW-1:0];
            end
        end
    end

    // Lock state of the captured target; out-of-range addresses select nothing.
    always_comb begin
        addr_bad   = ({1'b0, addr_q} >= NREGS_EXT);
        sel_locked = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (addr_q == AW'(i)) begin
                sel_locked = lock_q[i];
            end
        end
    end

    // Next-state logic: arbitration/capture, policy checks and the single write.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lock_req_d = lock_req_q;
        debug_d    = debug_q;
        winner_d   = winner_q;
        status_d   = status_q;
        reg_d      = reg_q;
        lock_d     = lock_q | {NREGS{lock_all}};

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    addr_d     = req_addr[grant_id*AW +: AW];
                    data_d     = req_data[grant_id*DW +: DW];
                    lock_req_d = req_lock[grant_id];
                    debug_d    = req_debug[grant_id];
                    winner_d   = grant_id;
                    rr_ptr_d   = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // lock_all is folded in combinationally so a same-edge lock_all
                // beats the write.
                if (addr_bad) begin
                    status_d = RS_BAD_ADDR;
                end else if (sel_locked || lock_all) begin
                    status_d = RS_LOCKED;
                end else if (debug_q && !(debug_mode && trusted)) begin
                    status_d = RS_DENIED;
                end else begin
                    status_d = RS_OK;
                    for (int i = 0; i < NREGS; i++) begin
                        if (addr_q == AW'(i)) begin
                            reg_d[i] = data_q;
                            if (lock_req_q) begin
                                lock_d[i] = 1'b1;
                            end
                        end
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bank registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            lock_req_q <= 1'b0;
            debug_q    <= 1'b0;
            winner_q   <= '0;
            status_q   <= RS_OK;
            lock_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            lock_req_q <= lock_req_d;
            debug_q    <= debug_d;
            winner_q   <= winner_d;
            status_q   <= status_d;
            lock_q     <= lock_d;
            reg_q      <= reg_d;
        end
    end

    // One-hot grant and response pulses; grant is suppressed while in reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = resetn && (state_q == ST_IDLE) && grant_found
                           && (grant_id == IW'(i));
            rsp_valid[i] = (state_q == ST_RESP) && (winner_q == IW'(i));
        end
    end

    assign rsp_status  = status_q;
    assign lock_status = lock_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg_out
        assign reg_out[g*DW +: DW] = reg_q[g];
    end

endmodule

// File: tb/tb_locked_reg_write_arbiter.sv
// Self-checking bench for locked_reg_write_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_locked_reg_write_arbiter;

    localparam int NREQ  = 2;
    localparam int NREGS = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;

    localparam logic [1:0] S_OK = 2'b00, S_LOCKED = 2'b01, S_DENIED = 2'b10, S_BAD = 2'b11;

    logic                 Clk;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_debug;
    logic                 debug_mode;
    logic                 trusted;
    logic                 lock_all;
    logic [NREQ-1:0]      rsp_valid;
    logic [1:0]           rsp_status;
    logic [NREGS*DW-1:0]  reg_out;
    logic [NREGS-1:0]     lock_status;

    locked_reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .Clk(Clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_lock(req_lock), .req_debug(req_debug),
        .debug_mode(debug_mode), .trusted(trusted), .lock_all(lock_all),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .reg_out(reg_out), .lock_status(lock_status)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, lock bits, next requester to favour.
    logic [DW-1:0]    m_reg [NREGS];
    logic [NREGS-1:0] m_lock;
    int               m_rr;

    function automatic logic [NREGS*DW-1:0] model_bank();
        logic [NREGS*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[i*DW +: DW] = m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        m_lock = '0;
        m_rr   = 0;
    endtask

    task automatic set_req(input int i, input int addr, input logic [DW-1:0] data,
                           input logic lk, input logic dbg);
        req_addr[i*AW +: AW] = AW'(addr);
        req_data[i*DW +: DW] = data;
        req_lock[i]          = lk;
        req_debug[i]         = dbg;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        resetn    = 1'b0;
        req_valid = '0;
        lock_all  = 1'b0;
        repeat (2) @(negedge Clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // Drives one transaction from the IDLE cycle through the response and
    // checks grant, latency, status and bank state against the model.
    task automatic run_txn(input logic [NREQ-1:0] vmask, input logic la_exec,
                           output int w, output logic [1:0] st);
        logic [NREQ-1:0] exp_one;
        logic [1:0]      es;
        int              a;
        logic [DW-1:0]   d;
        logic            lk, dbg;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && vmask[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
        end
        exp_one    = '0;
        exp_one[w] = 1'b1;
        req_valid  = vmask;
        #1;
        checks++;
        if (req_ready !== exp_one) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_one);
        end
        m_rr = (w + 1) % NREQ;
        a    = int'(req_addr[w*AW +: AW]);
        d    = req_data[w*DW +: DW];
        lk   = req_lock[w];
        dbg  = req_debug[w];

        @(negedge Clk);
        req_valid = '0;
        lock_all  = la_exec;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL exec_quiet: req_ready=%b rsp_valid=%b expected 0", req_ready, rsp_valid);
        end
        if (a >= NREGS)                               es = S_BAD;
        else if (m_lock[a] || la_exec)                es = S_LOCKED;
        else if (dbg && !(debug_mode && trusted))     es = S_DENIED;
        else begin
            es       = S_OK;
            m_reg[a] = d;
            if (lk) m_lock[a] = 1'b1;
        end
        if (la_exec) m_lock = '1;

        @(negedge Clk);
        lock_all = 1'b0;
        checks++;
        if (rsp_valid !== exp_one) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_one);
        end
        checks++;
        if (rsp_status !== es) begin
            errors++;
            $display("FAIL rsp_status: got %b expected %b (addr %0d)", rsp_status, es, a);
        end
        checks++;
        if (reg_out !== model_bank()) begin
            errors++;
            $display("FAIL reg_out: got %h expected %h", reg_out, model_bank());
        end
        checks++;
        if (lock_status !== m_lock) begin
            errors++;
            $display("FAIL lock_status: got %b expected %b", lock_status, m_lock);
        end
        st = rsp_status;

        @(negedge Clk);
        checks++;
        if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL rsp_one_cycle: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_status !== 2'b00 ||
            reg_out !== '0 || lock_status !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rsp=%b st=%b regs=%h locks=%b expected all 0",
                     req_ready, rsp_valid, rsp_status, reg_out, lock_status);
        end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_write();
        int w; logic [1:0] st;
        set_req(0, 1, 16'hA5A5, 1'b0, 1'b0);
        run_txn(2'b01, 1'b0, w, st);
        checks++;
        if (st !== S_OK || reg_out[1*DW +: DW] !== 16'hA5A5 || lock_status !== '0) begin
            errors++;
            $display("FAIL basic_write: st=%b reg1=%h locks=%b expected 00 a5a5 0000",
                     st, reg_out[1*DW +: DW], lock_status);
        end
    endtask

    task automatic test_lock_sticky();
        int w; logic [1:0] st1, st2;
        set_req(0, 2, 16'h1234, 1'b1, 1'b0);
        run_txn(2'b01, 1'b0, w, st1);
        set_req(0, 2, 16'hFFFF, 1'b0, 1'b0);
        run_txn(2'b01, 1'b0, w, st2);
        checks++;
        if (st1 !== S_OK || st2 !== S_LOCKED || reg_out[2*DW +: DW] !== 16'h1234 || lock_status[2] !== 1'b1) begin
            errors++;
            $display("FAIL lock_sticky: st=%b,%b reg2=%h lock2=%b expected 00,01 1234 1",
                     st1, st2, reg_out[2*DW +: DW], lock_status[2]);
        end
    endtask

    task automatic test_no_debug_override();
        int w; logic [1:0] st;
        debug_mode = 1'b1; trusted = 1'b1;
        set_req(1, 2, 16'hDEAD, 1'b0, 1'b1);
        run_txn(2'b10, 1'b0, w, st);
        checks++;
        if (st !== S_LOCKED || reg_out[2*DW +: DW] !== 16'h1234) begin
            errors++;
            $display("FAIL no_debug_override: st=%b reg2=%h expected 01 1234", st, reg_out[2*DW +: DW]);
        end
    endtask

    task automatic test_debug_trust();
        int w; logic [1:0] st;
        debug_mode = 1'b1; trusted = 1'b0;
        set_req(1, 0, 16'h5A5A, 1'b0, 1'b1);
        run_txn(2'b10, 1'b0, w, st);
        checks++;
        if (st !== S_DENIED || reg_out[0 +: DW] !== 16'h0000) begin
            errors++;
            $display("FAIL debug_untrusted: st=%b reg0=%h expected 10 0000", st, reg_out[0 +: DW]);
        end
        trusted = 1'b1;
        run_txn(2'b10, 1'b0, w, st);
        checks++;
        if (st !== S_OK || reg_out[0 +: DW] !== 16'h5A5A) begin
            errors++;
            $display("FAIL debug_trusted: st=%b reg0=%h expected 00 5a5a", st, reg_out[0 +: DW]);
        end
        debug_mode = 1'b0; trusted = 1'b0;
    endtask

    task automatic test_round_robin();
        int w; logic [1:0] st;
        do_reset();
        set_req(0, 0, 16'h1111, 1'b0, 1'b0);
        set_req(1, 3, 16'h2222, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run_txn(2'b11, 1'b0, w, st);
            checks++;
            if (w !== (t % 2)) begin
                errors++;
                $display("FAIL round_robin: txn %0d winner %0d expected %0d", t, w, t % 2);
            end
        end
    endtask

    task automatic test_bad_addr();
        int w; logic [1:0] st;
        set_req(0, NREGS, 16'hBAD0, 1'b1, 1'b0);
        run_txn(2'b01, 1'b0, w, st);
        set_req(1, 15, 16'hBAD1, 1'b1, 1'b0);
        run_txn(2'b10, 1'b0, w, st);
        checks++;
        if (st !== S_BAD || lock_status !== '0) begin
            errors++;
            $display("FAIL bad_addr: st=%b locks=%b expected 11 0000", st, lock_status);
        end
    endtask

    task automatic test_random();
        int w; logic [1:0] st;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom_range(0, 5), DW'($urandom),
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
            end
            debug_mode = 1'($urandom_range(0, 1));
            trusted    = 1'($urandom_range(0, 1));
            run_txn(NREQ'($urandom_range(1, 3)), 1'b0, w, st);
            if ($urandom_range(0, 3) == 0) @(negedge Clk);
        end
        debug_mode = 1'b0; trusted = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        int w; logic [1:0] st;
        do_reset();
        set_req(0, 3, 16'hBEEF, 1'b1, 1'b0);
        req_valid = 2'b01;
        @(negedge Clk);
        req_valid = '0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge Clk);
        resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            checks++;
            if (rsp_valid !== '0 || reg_out !== '0 || lock_status !== '0) begin
                errors++;
                $display("FAIL reset_mid_txn: rsp=%b regs=%h locks=%b expected all 0",
                         rsp_valid, reg_out, lock_status);
            end
        end
        set_req(1, 3, 16'hC0DE, 1'b0, 1'b0);
        run_txn(2'b11, 1'b0, w, st);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL rr_after_reset: winner %0d expected 0", w);
        end
    endtask

    task automatic test_lock_all();
        int w; logic [1:0] st;
        do_reset();
        set_req(0, 1, 16'h7777, 1'b0, 1'b0);
        run_txn(2'b01, 1'b1, w, st);
        checks++;
        if (st !== S_LOCKED || reg_out[1*DW +: DW] !== 16'h0000) begin
            errors++;
            $display("FAIL lock_all_same_edge: st=%b reg1=%h expected 01 0000", st, reg_out[1*DW +: DW]);
        end
        do_reset();
        lock_all = 1'b1;
        @(negedge Clk);
        lock_all = 1'b0;
        m_lock = '1;
        checks++;
        if (lock_status !== '1) begin
            errors++;
            $display("FAIL lock_all_pulse: locks=%b expected all 1", lock_status);
        end
        for (int r = 0; r < NREGS; r++) begin
            set_req(r % NREQ, r, 16'hF00D, 1'b0, 1'b0);
            run_txn(NREQ'(1 << (r % NREQ)), 1'b0, w, st);
            checks++;
            if (st !== S_LOCKED) begin
                errors++;
                $display("FAIL lock_all_write: reg %0d st=%b expected 01", r, st);
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        req_lock   = '0;
        req_debug  = '0;
        debug_mode = 1'b0;
        trusted    = 1'b0;
        lock_all   = 1'b0;
        model_reset();

        test_reset();
        test_basic_write();
        test_lock_sticky();
        test_no_debug_override();
        test_debug_trust();
        test_round_robin();
        test_bad_addr();
        test_random();
        test_reset_mid_txn();
        test_lock_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
